// File: rtl/l1_snooper_pkg.sv
// Shared types for the L1 snoop responder: MESI states, bus request codes,
// line address/data widths and the writeback entry layout.
package l1_snooper_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int CACHELINE_BITS = 512;
  localparam int LINE_BITS      = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S,
    MESI_E,
    MESI_M
  } mesi_t;

  typedef enum logic [1:0] {
    BUS_RD = 2'd0,
    BUS_RDX,
    BUS_UPGR,
    BUS_WB
  } bus_req_t;

  typedef logic [LINE_BITS-1:0]      line_addr_t;
  typedef logic [CACHELINE_BITS-1:0] line_data_t;

  typedef struct packed {
    line_addr_t addr;
    line_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/l1_snooper_if.sv
// Snoop channel between the coherence bus (master) and one L1 snooper (slave).
interface l1_snooper_if;
  import l1_snooper_pkg::*;

  logic       snoop_valid;
  line_addr_t snoop_addr;
  bus_req_t   snoop_req;
  logic       snoop_shared;
  line_data_t snoop_data;
  logic       snoop_busy;

  modport master (
    output snoop_valid, snoop_addr, snoop_req,
    input  snoop_shared, snoop_data, snoop_busy
  );

  modport slave (
    input  snoop_valid, snoop_addr, snoop_req,
    output snoop_shared, snoop_data, snoop_busy
  );
endinterface

// File: rtl/l1_snoop_wb_fifo.sv
// Writeback queue for lines demoted M->S. Entries can be cancelled by address;
// cancelled entries at the head are skipped without a handshake.
module l1_snoop_wb_fifo
  import l1_snooper_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enq_valid,
  input  line_addr_t enq_addr,
  input  line_data_t enq_data,
  input  logic       cancel_valid,
  input  line_addr_t cancel_addr,
  output logic       wb_valid,
  input  logic       wb_ready,
  output line_addr_t wb_addr,
  output line_data_t wb_data,
  output logic       err_overflow
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int PTR_W    = PTR_BITS + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             err_overflow_q, err_overflow_d;
  wb_entry_t        mem_q [DEPTH];

  logic [DEPTH-1:0] live;
  logic [PTR_W-1:0] cnt, head_ptr, p;
  logic             full, found, pop, do_enq;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    full     = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
               (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    cnt      = wr_ptr_q - rd_ptr_q;
    p        = '0;
    found    = 1'b0;
    head_ptr = rd_ptr_q;

    // A cancel takes effect in the snoop cycle itself, so mask it before picking the head.
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = vld_q[i] && !(cancel_valid && (mem_q[i].addr == cancel_addr));
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      p = rd_ptr_q + PTR_W'(i);
      if ((PTR_W'(i) < cnt) && live[p[PTR_BITS-1:0]]) begin
        found    = 1'b1;
        head_ptr = p;
      end
    end

    pop      = found && wb_ready;
    wb_valid = found;
    wb_addr  = found ? mem_q[head_ptr[PTR_BITS-1:0]].addr : '0;
    wb_data  = found ? mem_q[head_ptr[PTR_BITS-1:0]].data : '0;

    do_enq   = enq_valid && (!full || pop);
    rd_ptr_d = found ? (head_ptr + PTR_W'(pop)) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_enq);

    vld_d = live;
    if (pop) vld_d[head_ptr[PTR_BITS-1:0]] = 1'b0;
    if (do_enq) vld_d[wr_ptr_q[PTR_BITS-1:0]] = 1'b1;

    err_overflow_d = err_overflow_q | (enq_valid && !do_enq);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      vld_q          <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      vld_q          <= vld_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // NOTE: payload storage is not reset; the per-entry valid bits alone define what is queued.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= '{addr: enq_addr, data: enq_data};
  end

  assign err_overflow = err_overflow_q;

endmodule

// File: rtl/l1_snooper.sv
// Per-core snoop responder: looks up snooped lines in the L1 arrays, applies
// MESI transitions, answers the bus one cycle later and queues M->S writebacks.
module l1_snooper
  import l1_snooper_pkg::*;
#(
  parameter  int WAYS       = 2,
  parameter  int INDEX_BITS = 6,
  parameter  int WB_DEPTH   = 4,
  localparam int TAG_BITS   = LINE_BITS - INDEX_BITS,
  localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  l1_snooper_if.slave                    bus,
  output logic [INDEX_BITS-1:0]          arr_rd_index,
  input  logic [WAYS*TAG_BITS-1:0]       arr_rd_tag,
  input  logic [WAYS*2-1:0]              arr_rd_state,
  input  logic [WAYS*CACHELINE_BITS-1:0] arr_rd_data,
  output logic                           arr_wr_en,
  output logic [INDEX_BITS-1:0]          arr_wr_index,
  output logic [WAY_BITS-1:0]            arr_wr_way,
  output mesi_t                          arr_wr_state,
  output logic                           inval_valid,
  output line_addr_t                     inval_addr,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output line_addr_t                     wb_addr,
  output line_data_t                     wb_data,
  output logic                           err_overflow,
  output logic                           err_protocol
);

  logic [TAG_BITS-1:0] snoop_tag;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  mesi_t               hit_state;
  line_data_t          hit_line;
  logic                enq, cancel, proto_err;

  logic       snoop_shared_q, snoop_shared_d;
  line_data_t snoop_data_q, snoop_data_d;
  logic       err_protocol_q, err_protocol_d;

  always_comb begin
    snoop_tag = bus.snoop_addr[LINE_BITS-1:INDEX_BITS];
    hit       = 1'b0;
    hit_way   = '0;
    hit_state = MESI_I;
    hit_line  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.snoop_valid && (arr_rd_tag[w*TAG_BITS +: TAG_BITS] == snoop_tag) &&
          (mesi_t'(arr_rd_state[w*2 +: 2]) != MESI_I)) begin
        hit       = 1'b1;
        hit_way   = WAY_BITS'(w);
        hit_state = mesi_t'(arr_rd_state[w*2 +: 2]);
        hit_line  = arr_rd_data[w*CACHELINE_BITS +: CACHELINE_BITS];
      end
    end
  end

  always_comb begin
    arr_wr_en    = 1'b0;
    arr_wr_state = MESI_I;
    inval_valid  = 1'b0;
    enq          = 1'b0;
    proto_err    = 1'b0;
    cancel       = bus.snoop_valid && (bus.snoop_req inside {BUS_RDX, BUS_UPGR});
    if (hit) begin
      unique case (bus.snoop_req)
        BUS_RD: begin
          if (hit_state inside {MESI_M, MESI_E}) begin
            arr_wr_en    = 1'b1;
            arr_wr_state = MESI_S;
            enq          = (hit_state == MESI_M);
          end
        end
        BUS_RDX: begin
          arr_wr_en   = 1'b1;
          inval_valid = 1'b1;
        end
        BUS_UPGR: begin
          // A peer upgrading means it believes it holds S; we must not be exclusive.
          arr_wr_en   = 1'b1;
          inval_valid = 1'b1;
          proto_err   = (hit_state inside {MESI_E, MESI_M});
        end
        BUS_WB: proto_err = (hit_state inside {MESI_E, MESI_M});
        default: ;
      endcase
    end

    snoop_shared_d = hit && (bus.snoop_req inside {BUS_RD, BUS_RDX});
    snoop_data_d   = snoop_shared_d ? hit_line : '0;
    err_protocol_d = err_protocol_q | proto_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snoop_shared_q <= 1'b0;
      snoop_data_q   <= '0;
      err_protocol_q <= 1'b0;
    end else begin
      snoop_shared_q <= snoop_shared_d;
      snoop_data_q   <= snoop_data_d;
      err_protocol_q <= err_protocol_d;
    end
  end

  assign bus.snoop_busy   = bus.snoop_valid;
  assign bus.snoop_shared = snoop_shared_q;
  assign bus.snoop_data   = snoop_data_q;
  assign arr_rd_index     = bus.snoop_addr[INDEX_BITS-1:0];
  assign arr_wr_index     = bus.snoop_addr[INDEX_BITS-1:0];
  assign arr_wr_way       = hit_way;
  assign inval_addr       = inval_valid ? bus.snoop_addr : '0;
  assign err_protocol     = err_protocol_q;

  l1_snoop_wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .enq_valid    (enq),
    .enq_addr     (bus.snoop_addr),
    .enq_data     (hit_line),
    .cancel_valid (cancel),
    .cancel_addr  (bus.snoop_addr),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .err_overflow (err_overflow)
  );

endmodule

// File: tb/tb_l1_snooper.sv
// Bench for l1_snooper: array memory model, queue-based writeback model,
// directed scenarios followed by randomized snoop traffic.
module tb_l1_snooper;
  import l1_snooper_pkg::*;

  localparam int WAYS       = 2;
  localparam int INDEX_BITS = 6;
  localparam int WB_DEPTH   = 4;
  localparam int TAG_BITS   = LINE_BITS - INDEX_BITS;
  localparam int SETS       = 1 << INDEX_BITS;

  typedef struct {
    line_addr_t addr;
    line_data_t data;
    bit         v;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l1_snooper_if bif ();

  logic [INDEX_BITS-1:0]          arr_rd_index;
  logic [WAYS*TAG_BITS-1:0]       arr_rd_tag;
  logic [WAYS*2-1:0]              arr_rd_state;
  logic [WAYS*CACHELINE_BITS-1:0] arr_rd_data;
  logic                           arr_wr_en;
  logic [INDEX_BITS-1:0]          arr_wr_index;
  logic [0:0]                     arr_wr_way;
  mesi_t                          arr_wr_state;
  logic                           inval_valid;
  line_addr_t                     inval_addr;
  logic                           wb_valid, wb_ready;
  line_addr_t                     wb_addr;
  line_data_t                     wb_data;
  logic                           err_overflow, err_protocol;

  l1_snooper #(.WAYS(WAYS), .INDEX_BITS(INDEX_BITS), .WB_DEPTH(WB_DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bif),
    .arr_rd_index (arr_rd_index),
    .arr_rd_tag   (arr_rd_tag),
    .arr_rd_state (arr_rd_state),
    .arr_rd_data  (arr_rd_data),
    .arr_wr_en    (arr_wr_en),
    .arr_wr_index (arr_wr_index),
    .arr_wr_way   (arr_wr_way),
    .arr_wr_state (arr_wr_state),
    .inval_valid  (inval_valid),
    .inval_addr   (inval_addr),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  // L1 arrays as seen by the snooper; written only from the stimulus process.
  logic [TAG_BITS-1:0] m_tag   [SETS][WAYS];
  mesi_t               m_state [SETS][WAYS];
  line_data_t          m_data  [SETS][WAYS];

  always_comb begin
    arr_rd_tag   = '0;
    arr_rd_state = '0;
    arr_rd_data  = '0;
    for (int w = 0; w < WAYS; w++) begin
      arr_rd_tag[w*TAG_BITS +: TAG_BITS]             = m_tag[arr_rd_index][w];
      arr_rd_state[w*2 +: 2]                         = m_state[arr_rd_index][w];
      arr_rd_data[w*CACHELINE_BITS +: CACHELINE_BITS] = m_data[arr_rd_index][w];
    end
  end

  int   n_cmp = 0;
  int   n_mis = 0;
  ent_t q[$];
  bit   m_ovf  = 1'b0;
  bit   m_perr = 1'b0;

  task automatic check(input string tag, input logic [CACHELINE_BITS-1:0] obs,
                       input logic [CACHELINE_BITS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic line_data_t rand_line();
    line_data_t d;
    for (int i = 0; i < CACHELINE_BITS / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic put(input line_addr_t a, input int w, input mesi_t s, input line_data_t d);
    m_tag[a[INDEX_BITS-1:0]][w]   = a[LINE_BITS-1:INDEX_BITS];
    m_state[a[INDEX_BITS-1:0]][w] = s;
    m_data[a[INDEX_BITS-1:0]][w]  = d;
  endtask

  // One bus cycle; entered just after a falling edge, returns at the next one.
  task automatic step(input logic v, input line_addr_t a, input bus_req_t r, input logic rdy);
    int idx, hw, h, cap_idx, cap_way;
    logic [TAG_BITS-1:0] tg;
    bit hit, e_wr, e_inv, e_enq, e_perr, e_sh, full, pop, cap_wr;
    mesi_t hs, e_st, cap_st;
    line_data_t hl;

    bif.snoop_valid = v;
    bif.snoop_addr  = a;
    bif.snoop_req   = r;
    wb_ready        = rdy;
    #1;

    idx = int'(a[INDEX_BITS-1:0]);
    tg  = a[LINE_BITS-1:INDEX_BITS];
    hit = 1'b0; hw = 0; hs = MESI_I; hl = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_state[idx][w] != MESI_I && m_tag[idx][w] == tg) begin
        hit = 1'b1; hw = w; hs = m_state[idx][w]; hl = m_data[idx][w];
      end
    end
    hit = hit && v;
    e_wr = 1'b0; e_inv = 1'b0; e_enq = 1'b0; e_perr = 1'b0; e_st = MESI_I;
    if (hit) begin
      case (r)
        BUS_RD:   if (hs == MESI_M || hs == MESI_E) begin e_wr = 1'b1; e_st = MESI_S; e_enq = (hs == MESI_M); end
        BUS_RDX:  begin e_wr = 1'b1; e_inv = 1'b1; end
        BUS_UPGR: begin e_wr = 1'b1; e_inv = 1'b1; e_perr = (hs == MESI_M || hs == MESI_E); end
        default:  e_perr = (hs == MESI_M || hs == MESI_E);
      endcase
    end
    e_sh = hit && (r == BUS_RD || r == BUS_RDX);

    full = (q.size() == WB_DEPTH);
    if (v && (r == BUS_RDX || r == BUS_UPGR))
      foreach (q[i]) if (q[i].addr == a) q[i].v = 1'b0;
    h = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].v && h < 0) h = i;

    check("snoop_busy", bif.snoop_busy, v);
    check("arr_rd_index", arr_rd_index, a[INDEX_BITS-1:0]);
    check("arr_wr_en", arr_wr_en, e_wr);
    if (e_wr) begin
      check("arr_wr_index", arr_wr_index, a[INDEX_BITS-1:0]);
      check("arr_wr_way", arr_wr_way, hw);
      check("arr_wr_state", arr_wr_state, e_st);
    end
    check("inval_valid", inval_valid, e_inv);
    if (e_inv) check("inval_addr", inval_addr, a);
    check("wb_valid", wb_valid, h >= 0);
    if (h >= 0) begin
      check("wb_addr", wb_addr, q[h].addr);
      check("wb_data", wb_data, q[h].data);
    end

    cap_wr = arr_wr_en; cap_idx = int'(arr_wr_index); cap_way = int'(arr_wr_way); cap_st = arr_wr_state;
    @(posedge clk);
    #1;
    if (cap_wr) m_state[cap_idx][cap_way] = cap_st;
    pop = (h >= 0) && rdy;
    if (h < 0) q.delete();
    else repeat (h + int'(pop)) void'(q.pop_front());
    if (e_enq) begin
      if (!full || pop) q.push_back('{addr: a, data: hl, v: 1'b1});
      else m_ovf = 1'b1;
    end
    if (e_perr) m_perr = 1'b1;

    check("snoop_shared", bif.snoop_shared, e_sh);
    check("snoop_data", bif.snoop_data, e_sh ? hl : '0);
    check("err_protocol", err_protocol, m_perr);
    check("err_overflow", err_overflow, m_ovf);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_shared"}, bif.snoop_shared, 1'b0);
    check({pfx, "_data"}, bif.snoop_data, '0);
    check({pfx, "_busy"}, bif.snoop_busy, 1'b0);
    check({pfx, "_rd_index"}, arr_rd_index, '0);
    check({pfx, "_wr_en"}, arr_wr_en, 1'b0);
    check({pfx, "_wr_index"}, arr_wr_index, '0);
    check({pfx, "_wr_way"}, arr_wr_way, '0);
    check({pfx, "_wr_state"}, arr_wr_state, MESI_I);
    check({pfx, "_inval_valid"}, inval_valid, 1'b0);
    check({pfx, "_inval_addr"}, inval_addr, '0);
    check({pfx, "_wb_valid"}, wb_valid, 1'b0);
    check({pfx, "_wb_addr"}, wb_addr, '0);
    check({pfx, "_wb_data"}, wb_data, '0);
    check({pfx, "_err_overflow"}, err_overflow, 1'b0);
    check({pfx, "_err_protocol"}, err_protocol, 1'b0);
  endtask

  line_addr_t pool [8];

  initial begin
    line_data_t a5 = {64{8'hA5}};
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0; m_state[s][w] = MESI_I; m_data[s][w] = '0;
      end
    reset_n = 1'b0;
    bif.snoop_valid = 1'b0; bif.snoop_addr = '0; bif.snoop_req = BUS_RD; wb_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // BUS_RD hit on an E line in way 1: demote to S, answer with its data.
    put(26'h0_0405, 0, MESI_S, rand_line());
    put(26'h0_0845, 1, MESI_E, a5);
    step(1'b1, 26'h0_0845, BUS_RD, 1'b0);
    check("t2_shared", bif.snoop_shared, 1'b1);
    check("t2_data", bif.snoop_data, a5);
    step(1'b0, '0, BUS_RD, 1'b0);
    check("t2_shared_clear", bif.snoop_shared, 1'b0);

    // BUS_RD hit on M line 0x123: writeback queued, then drained.
    put(26'h123, 0, MESI_M, {16{32'hDEADBEEF}});
    step(1'b1, 26'h123, BUS_RD, 1'b0);
    check("t3_wb_valid", wb_valid, 1'b1);
    check("t3_wb_addr", wb_addr, 26'h123);
    step(1'b0, '0, BUS_RD, 1'b1);
    check("t3_empty", wb_valid, 1'b0);

    // Invalidations: RDX on M, UPGR on S, then UPGR on E (protocol error).
    put(26'h2C7, 1, MESI_M, rand_line());
    step(1'b1, 26'h2C7, BUS_RDX, 1'b0);
    put(26'h1D8, 0, MESI_S, rand_line());
    step(1'b1, 26'h1D8, BUS_UPGR, 1'b0);
    check("t4_no_enq", wb_valid, 1'b0);
    put(26'h319, 0, MESI_E, rand_line());
    step(1'b1, 26'h319, BUS_UPGR, 1'b0);
    check("t4_err_protocol", err_protocol, 1'b1);

    // Cancel: queue 0x10 and 0x20, snoop RDX 0x10, head moves to 0x20.
    put(26'h10, 0, MESI_M, rand_line());
    put(26'h20, 0, MESI_M, rand_line());
    step(1'b1, 26'h10, BUS_RD, 1'b0);
    step(1'b1, 26'h20, BUS_RD, 1'b0);
    step(1'b1, 26'h10, BUS_RDX, 1'b0);
    check("t5_head", wb_addr, 26'h20);
    step(1'b0, '0, BUS_RD, 1'b1);
    check("t5_one_handshake", wb_valid, 1'b0);

    // Fill the queue, enqueue at full with a pop, then without.
    for (int i = 0; i < 6; i++) put(26'h100 + line_addr_t'(i), 0, MESI_M, rand_line());
    for (int i = 0; i < 4; i++) step(1'b1, 26'h100 + line_addr_t'(i), BUS_RD, 1'b0);
    step(1'b1, 26'h104, BUS_RD, 1'b1);
    check("t6_no_overflow", err_overflow, 1'b0);
    step(1'b1, 26'h105, BUS_RD, 1'b0);
    check("t6_overflow", err_overflow, 1'b1);

    // Reset in the middle of a cycle with the queue full and errors set.
    bif.snoop_valid = 1'b0; bif.snoop_addr = '0; wb_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete(); m_ovf = 1'b0; m_perr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic over a small pool of resident lines plus random misses.
    for (int k = 0; k < 8; k++) begin
      pool[k] = {TAG_BITS'(100 + k), INDEX_BITS'(k % 4)};
      put(pool[k], k / 4, mesi_t'($urandom_range(0, 3)), rand_line());
    end
    for (int n = 0; n < 400; n++) begin
      int k = int'($urandom_range(0, 7));
      line_addr_t a = ($urandom_range(0, 9) < 8) ? pool[k] : line_addr_t'($urandom());
      bit v = ($urandom_range(0, 3) != 0);
      if (!v) m_state[k % 4][k / 4] = mesi_t'($urandom_range(0, 3));
      step(v, a, bus_req_t'($urandom_range(0, 3)), 1'(($urandom_range(0, 2) != 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
